pipelined_register_file: RTL and testbench



---
 rtl/pipelined_register_file_pkg.sv | 17 +
 rtl/pipelined_register_file_scoreboard.sv | 62 ++++++
 rtl/pipelined_register_file.sv | 91 +++++++++
 tb/tb_pipelined_register_file.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pipelined_register_file_pkg.sv
// Shared defaults for the pipelined register file: geometry, stack-pointer
// reset value and the ecall halt condition.
package pipelined_register_file_pkg;

    localparam int          DEF_XLEN     = 32;
    localparam int          DEF_NREGS    = 32;
    localparam int          DEF_NRD      = 2;
    localparam int          DEF_SP_IDX   = 2;
    localparam int unsigned DEF_SP_INIT  = 32'h2ffc;
    localparam int          DEF_HALT_IDX = 17;
    localparam int unsigned DEF_HALT_VAL = 10;

    localparam int DEF_AW = $clog2(DEF_NREGS);

    typedef logic [DEF_AW-1:0] reg_idx_t;

endpackage

// File: rtl/pipelined_register_file_scoreboard.sv
// Busy scoreboard: one bit per register, set at issue and cleared at
// writeback, with a sticky flag for issuing onto a still-busy register.
module rf_scoreboard #(
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_en,
    input  logic [AW-1:0]     issue_rd,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic              flush,
    input  logic [NRD*AW-1:0] rs_addr,
    output logic [NRD-1:0]    rs_busy,
    output logic              sb_error
);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;
    logic             w_conflict;
    logic             r_sb_error;

    // Issue is applied after writeback so a same-cycle reissue leaves the bit set.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int i = 1; i < NREGS; i++) begin
            if (wr_en && (wr_addr == AW'(i)))
                w_busy_nxt[i] = 1'b0;
            if (issue_en && (issue_rd == AW'(i)))
                w_busy_nxt[i] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    assign w_conflict = issue_en && r_busy[issue_rd] &&
                        !(wr_en && (wr_addr == issue_rd));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy     <= '0;
            r_sb_error <= 1'b0;
        end else if (flush) begin
            r_busy     <= '0;
        end else begin
            r_busy     <= w_busy_nxt;
            if (w_conflict)
                r_sb_error <= 1'b1;
        end
    end

    always_comb begin
        for (int k = 0; k < NRD; k++) begin
            rs_busy[k] = r_busy[rs_addr[k*AW +: AW]] &
                         ~(wr_en && (wr_addr == rs_addr[k*AW +: AW]));
        end
    end

    assign sb_error = r_sb_error;

endmodule

// File: rtl/pipelined_register_file.sv
// General-purpose register file for the pipelined core: bypassed async reads,
// busy scoreboard for hazards and a sticky ecall halt flag.
module pipelined_register_file
    import pipelined_register_file_pkg::*;
#(
    parameter int          XLEN     = DEF_XLEN,
    parameter int          NREGS    = DEF_NREGS,
    parameter int          NRD      = DEF_NRD,
    parameter int          SP_IDX   = DEF_SP_IDX,
    parameter int unsigned SP_INIT  = DEF_SP_INIT,
    parameter int          HALT_IDX = DEF_HALT_IDX,
    parameter int unsigned HALT_VAL = DEF_HALT_VAL,
    parameter int          AW       = $clog2(NREGS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NRD*AW-1:0]           rs_addr,
    output logic [NRD*XLEN-1:0]         rs_data,
    output logic [NRD-1:0]              rs_busy,
    input  logic                        wr_en,
    input  logic [AW-1:0]               wr_addr,
    input  logic [XLEN-1:0]             wr_data,
    input  logic                        issue_en,
    input  logic [AW-1:0]               issue_rd,
    input  logic                        flush,
    input  logic                        is_ecall,
    output logic                        is_halted,
    output logic                        sb_error,
    output logic [NREGS-1:0][XLEN-1:0]  print_reg
);

    localparam logic [AW-1:0] HALT_A = AW'(HALT_IDX);

    logic [NREGS-1:0][XLEN-1:0] r_rf;
    logic                       r_halted;
    logic [XLEN-1:0]            w_halt_reg;
    logic                       w_wr_live;

    assign w_wr_live = wr_en && (wr_addr != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                r_rf[i] <= (i == SP_IDX) ? XLEN'(SP_INIT) : '0;
        end else if (w_wr_live) begin
            r_rf[wr_addr] <= wr_data;
        end
    end

    // x0 reads as zero even while it is the writeback target.
    always_comb begin
        for (int k = 0; k < NRD; k++) begin
            if (rs_addr[k*AW +: AW] == '0)
                rs_data[k*XLEN +: XLEN] = '0;
            else if (wr_en && (wr_addr == rs_addr[k*AW +: AW]))
                rs_data[k*XLEN +: XLEN] = wr_data;
            else
                rs_data[k*XLEN +: XLEN] = r_rf[rs_addr[k*AW +: AW]];
        end
    end

    assign w_halt_reg = (w_wr_live && (wr_addr == HALT_A)) ? wr_data : r_rf[HALT_A];

    always_ff @(posedge clk) begin
        if (reset)
            r_halted <= 1'b0;
        else if (is_ecall && (w_halt_reg == XLEN'(HALT_VAL)))
            r_halted <= 1'b1;
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .AW    (AW)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .issue_en (issue_en),
        .issue_rd (issue_rd),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .flush    (flush),
        .rs_addr  (rs_addr),
        .rs_busy  (rs_busy),
        .sb_error (sb_error)
    );

    assign is_halted = r_halted;
    assign print_reg = r_rf;

endmodule

// File: tb/tb_pipelined_register_file.sv
// Directed bench for pipelined_register_file: bypass, x0, scoreboard, flush,
// halt and reset priority, with hand-computed expectations.
module tb_pipelined_register_file;
    import pipelined_register_file_pkg::*;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic                       clk = 1'b0;
    logic                       reset;
    logic [NRD*AW-1:0]          rs_addr;
    logic [NRD*XLEN-1:0]        rs_data;
    logic [NRD-1:0]             rs_busy;
    logic                       wr_en;
    logic [AW-1:0]              wr_addr;
    logic [XLEN-1:0]            wr_data;
    logic                       issue_en;
    logic [AW-1:0]              issue_rd;
    logic                       flush;
    logic                       is_ecall;
    logic                       is_halted;
    logic                       sb_error;
    logic [NREGS-1:0][XLEN-1:0] print_reg;

    int n_chk  = 0;
    int n_fail = 0;

    pipelined_register_file dut (
        .clk       (clk),
        .reset     (reset),
        .rs_addr   (rs_addr),
        .rs_data   (rs_data),
        .rs_busy   (rs_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .issue_en  (issue_en),
        .issue_rd  (issue_rd),
        .flush     (flush),
        .is_ecall  (is_ecall),
        .is_halted (is_halted),
        .sb_error  (sb_error),
        .print_reg (print_reg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en    = 1'b0;
        issue_en = 1'b0;
        flush    = 1'b0;
        is_ecall = 1'b0;
        reset    = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rs_addr = {a1, a0};
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        issue_en = 1'b0; issue_rd = '0; flush = 1'b0; is_ecall = 1'b0;
        rs_addr = '0;
        tick(); tick();
        idle();
        rd(5'd2, 5'd5);
        #1;
        check("reset_sp", 64'(rs_data[31:0]), 64'h2ffc);
        check("reset_x5", 64'(rs_data[63:32]), 64'h0);
        check("reset_busy", 64'(rs_busy), 64'h0);
        check("reset_halt", 64'(is_halted), 64'h0);
        check("reset_sberr", 64'(sb_error), 64'h0);

        // write and issue to x0 are discarded
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'd5;
        issue_en = 1'b1; issue_rd = 5'd0;
        rd(5'd0, 5'd0);
        #1;
        check("x0_bypass", 64'(rs_data[31:0]), 64'h0);
        tick(); idle(); #1;
        check("x0_read", 64'(rs_data[31:0]), 64'h0);
        check("x0_busy", 64'(rs_busy), 64'h0);
        check("x0_array", 64'(print_reg[0]), 64'h0);

        // same-cycle bypass then registered value
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hdeadbeef;
        rd(5'd7, 5'd5);
        #1;
        check("x7_bypass", 64'(rs_data[31:0]), 64'hdeadbeef);
        check("x7_other", 64'(rs_data[63:32]), 64'h0);
        tick(); idle(); #1;
        check("x7_stored", 64'(rs_data[31:0]), 64'hdeadbeef);
        check("x7_array", 64'(print_reg[7]), 64'hdeadbeef);

        // issue then writeback of x9
        issue_en = 1'b1; issue_rd = 5'd9;
        rd(5'd9, 5'd9);
        #1;
        check("x9_busy_before", 64'(rs_busy), 64'h0);
        tick(); idle(); #1;
        check("x9_busy", 64'(rs_busy), 64'h3);
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
        #1;
        check("x9_wb_busy", 64'(rs_busy), 64'h0);
        check("x9_wb_data", 64'(rs_data[31:0]), 64'h99);
        tick(); idle(); #1;
        check("x9_cleared", 64'(rs_busy), 64'h0);

        // same-cycle issue and writeback of x4: issue wins
        issue_en = 1'b1; issue_rd = 5'd4;
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h44;
        rd(5'd4, 5'd4);
        tick(); idle(); #1;
        check("x4_busy", 64'(rs_busy), 64'h3);
        check("x4_noerr", 64'(sb_error), 64'h0);
        check("x4_data", 64'(rs_data[31:0]), 64'h44);
        issue_en = 1'b1; issue_rd = 5'd4;
        tick(); idle(); #1;
        check("x4_sberr", 64'(sb_error), 64'h1);

        // flush clears busy and drops the same-cycle issue
        issue_en = 1'b1; issue_rd = 5'd6; flush = 1'b1;
        rd(5'd6, 5'd4);
        tick(); idle(); #1;
        check("flush_busy", 64'(rs_busy), 64'h0);
        check("sberr_sticky", 64'(sb_error), 64'h1);

        // halt via bypassed x17
        wr_en = 1'b1; wr_addr = 5'd17; wr_data = 32'd10; is_ecall = 1'b1;
        rd(5'd17, 5'd17);
        #1;
        check("halt_not_yet", 64'(is_halted), 64'h0);
        tick(); idle(); #1;
        check("halt_set", 64'(is_halted), 64'h1);
        wr_en = 1'b1; wr_addr = 5'd17; wr_data = 32'd3;
        tick(); idle(); #1;
        check("halt_sticky", 64'(is_halted), 64'h1);
        check("halt_write", 64'(rs_data[31:0]), 64'h3);

        reset = 1'b1;
        tick(); idle(); #1;
        check("halt_reset", 64'(is_halted), 64'h0);
        check("sberr_reset", 64'(sb_error), 64'h0);
        check("x17_reset", 64'(rs_data[31:0]), 64'h0);

        wr_en = 1'b1; wr_addr = 5'd17; wr_data = 32'd9;
        tick(); idle();
        is_ecall = 1'b1;
        tick(); idle(); #1;
        check("halt_x17_9", 64'(is_halted), 64'h0);

        // stored 10 overridden by bypassed 9 at the ecall
        wr_en = 1'b1; wr_addr = 5'd17; wr_data = 32'd10;
        tick(); idle();
        wr_en = 1'b1; wr_addr = 5'd17; wr_data = 32'd9; is_ecall = 1'b1;
        tick(); idle(); #1;
        check("halt_bypass_9", 64'(is_halted), 64'h0);

        // reset beats same-edge write and issue
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h55;
        tick(); idle();
        reset = 1'b1;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h77;
        issue_en = 1'b1; issue_rd = 5'd3;
        tick(); idle();
        rd(5'd3, 5'd2);
        #1;
        check("rst_x3", 64'(rs_data[31:0]), 64'h0);
        check("rst_sp", 64'(rs_data[63:32]), 64'h2ffc);
        check("rst_busy", 64'(rs_busy), 64'h0);
        check("rst_array_sp", 64'(print_reg[2]), 64'h2ffc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
